freq_cfg_ctrl: RTL and testbench

FREQ_CFG_CTRL -- requirements
Module: freq_cfg_ctrl

---
 rtl/freq_cfg_ctrl.sv | 206 ++++++++++++++++++++
 tb/tb_freq_cfg_ctrl.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/freq_cfg_ctrl.sv
// rtl/freq_cfg_ctrl.sv - UART byte-frame parser that commits DDS frequency words
//
// Purpose: parses frames of the form
//   A5, addr, lo, hi [, csum]
// and commits {hi,lo} to freq0 (addr=00) or freq1 (addr=01).
// An inter-byte timeout aborts stalled frames.
//
// Build option: FREQ_CFG_CHECKSUM_EN
//   When defined, a trailing checksum byte (addr^lo^hi) is required.
//
// Ports:
//   clk, rst            clock; asynchronous active-high reset
//   rx_valid, rx_data   one-cycle strobe and received UART byte
//   freq0, freq1        committed frequency words
//   update, upd_ch      commit pulse; channel of the last commit
//   err, err_code       abort pulse; cause of the last abort
//                       (01 address, 10 checksum, 11 timeout)
//   busy                frame in progress
module freq_cfg_ctrl #(
    parameter int          TIMEOUT_CYCLES = 52100,
    parameter logic [15:0] FREQ0_RST      = 16'h0000,
    parameter logic [15:0] FREQ1_RST      = 16'h0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_valid,
    input  logic [7:0]  rx_data,
    output logic [15:0] freq0,
    output logic [15:0] freq1,
    output logic        update,
    output logic        upd_ch,
    output logic        err,
    output logic [1:0]  err_code,
    output logic        busy
);

    localparam int             CW       = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_LO,
        S_HI
`ifdef FREQ_CFG_CHECKSUM_EN
        ,
        S_CSUM
`endif
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          ch_q, ch_d;
    logic [7:0]    lo_q, lo_d;
    logic [7:0]    hi_q, hi_d;
    logic [15:0]   freq0_q, freq0_d;
    logic [15:0]   freq1_q, freq1_d;
    logic          update_q, update_d;
    logic          upd_ch_q, upd_ch_d;
    logic          err_q, err_d;
    logic [1:0]    err_code_q, err_code_d;
    logic          busy_q, busy_d;

    logic          commit;
    logic [15:0]   commit_word;
    logic [CW-1:0] cnt_inc;

    always_comb begin
        state_d     = state_q;
        ch_d        = ch_q;
        lo_d        = lo_q;
        hi_d        = hi_q;
        freq0_d     = freq0_q;
        freq1_d     = freq1_q;
        update_d    = 1'b0;
        upd_ch_d    = upd_ch_q;
        err_d       = 1'b0;
        err_code_d  = err_code_q;
        commit      = 1'b0;
        commit_word = {hi_q, lo_q};
        cnt_inc     = cnt_q + CW'(1);

        // Counter idles at zero and restarts on every accepted byte.
        if (state_q == S_IDLE || rx_valid) begin
            cnt_d = '0;
        end else begin
            cnt_d = cnt_inc;
        end

        case (state_q)
            S_IDLE: begin
                // Non-sync bytes are dropped silently while hunting.
                if (rx_valid && rx_data == 8'hA5) begin
                    state_d = S_ADDR;
                end
            end
            S_ADDR: begin
                if (rx_valid) begin
                    if (rx_data[7:1] == 7'd0) begin
                        ch_d    = rx_data[0];
                        state_d = S_LO;
                    end else begin
                        err_d      = 1'b1;
                        err_code_d = 2'b01;
                        state_d    = S_IDLE;
                    end
                end
            end
            S_LO: begin
                if (rx_valid) begin
                    lo_d    = rx_data;
                    state_d = S_HI;
                end
            end
            S_HI: begin
                if (rx_valid) begin
                    hi_d = rx_data;
`ifdef FREQ_CFG_CHECKSUM_EN
                    state_d = S_CSUM;
`else
                    commit      = 1'b1;
                    commit_word = {rx_data, lo_q};
`endif
                end
            end
`ifdef FREQ_CFG_CHECKSUM_EN
            S_CSUM: begin
                if (rx_valid) begin
                    // The address byte is known to be {7'b0, ch} here.
                    if (rx_data == ({7'd0, ch_q} ^ lo_q ^ hi_q)) begin
                        commit = 1'b1;
                    end else begin
                        err_d      = 1'b1;
                        err_code_d = 2'b10;
                        state_d    = S_IDLE;
                    end
                end
            end
`endif
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Expiry is the idle cycle on which the counter would reach its
        // last value; a byte arriving in that cycle takes precedence.
        if (state_q != S_IDLE && !rx_valid && cnt_inc == CNT_LAST) begin
            err_d      = 1'b1;
            err_code_d = 2'b11;
            state_d    = S_IDLE;
            cnt_d      = '0;
        end

        if (commit) begin
            if (ch_q) begin
                freq1_d = commit_word;
            end else begin
                freq0_d = commit_word;
            end
            upd_ch_d = ch_q;
            update_d = 1'b1;
            state_d  = S_IDLE;
        end

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            ch_q       <= 1'b0;
            lo_q       <= 8'd0;
            hi_q       <= 8'd0;
            freq0_q    <= FREQ0_RST;
            freq1_q    <= FREQ1_RST;
            update_q   <= 1'b0;
            upd_ch_q   <= 1'b0;
            err_q      <= 1'b0;
            err_code_q <= 2'b00;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            ch_q       <= ch_d;
            lo_q       <= lo_d;
            hi_q       <= hi_d;
            freq0_q    <= freq0_d;
            freq1_q    <= freq1_d;
            update_q   <= update_d;
            upd_ch_q   <= upd_ch_d;
            err_q      <= err_d;
            err_code_q <= err_code_d;
            busy_q     <= busy_d;
        end
    end

    assign freq0    = freq0_q;
    assign freq1    = freq1_q;
    assign update   = update_q;
    assign upd_ch   = upd_ch_q;
    assign err      = err_q;
    assign err_code = err_code_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_freq_cfg_ctrl.sv
// tb/tb_freq_cfg_ctrl.sv - self-checking bench for freq_cfg_ctrl
module tb_freq_cfg_ctrl;

    localparam int          T    = 16;
    localparam logic [15:0] F0R  = 16'h1111;
    localparam logic [15:0] F1R  = 16'h2222;
`ifdef FREQ_CFG_CHECKSUM_EN
    localparam bit CSUM_EN = 1'b1;
    localparam int FLEN    = 5;
`else
    localparam bit CSUM_EN = 1'b0;
    localparam int FLEN    = 4;
`endif

    logic        clk = 1'b0;
    logic        rst;
    logic        rx_valid;
    logic [7:0]  rx_data;
    logic [15:0] freq0, freq1;
    logic        update, upd_ch, err, busy;
    logic [1:0]  err_code;

    int n_cmp  = 0;
    int n_fail = 0;

    freq_cfg_ctrl #(
        .TIMEOUT_CYCLES(T),
        .FREQ0_RST(F0R),
        .FREQ1_RST(F1R)
    ) dut (
        .clk(clk), .rst(rst), .rx_valid(rx_valid), .rx_data(rx_data),
        .freq0(freq0), .freq1(freq1), .update(update), .upd_ch(upd_ch),
        .err(err), .err_code(err_code), .busy(busy)
    );

    always #5 clk = ~clk;

    // Reference model: the frame is kept as a list of received bytes.
    logic [7:0]  frame[$];
    int          idle;
    logic [15:0] m_f0, m_f1;
    logic        m_upd, m_ch, m_err;
    logic [1:0]  m_code;

    task automatic model_reset();
        frame.delete();
        idle = 0;
        m_f0 = F0R; m_f1 = F1R;
        m_upd = 0; m_ch = 0; m_err = 0; m_code = 2'b00;
    endtask

    task automatic model_abort(input logic [1:0] c);
        m_err  = 1'b1;
        m_code = c;
        frame.delete();
    endtask

    task automatic model_step(input logic v, input logic [7:0] d);
        m_upd = 1'b0;
        m_err = 1'b0;
        if (frame.size() == 0) begin
            idle = 0;
            if (v && d == 8'hA5) frame.push_back(d);
        end else if (v) begin
            idle = 0;
            frame.push_back(d);
            if (frame.size() == 2 && d[7:1] != 7'd0) begin
                model_abort(2'b01);
            end else if (frame.size() == FLEN) begin
                if (CSUM_EN && d != (frame[1] ^ frame[2] ^ frame[3])) begin
                    model_abort(2'b10);
                end else begin
                    if (frame[1][0]) m_f1 = {frame[3], frame[2]};
                    else             m_f0 = {frame[3], frame[2]};
                    m_ch  = frame[1][0];
                    m_upd = 1'b1;
                    frame.delete();
                end
            end
        end else begin
            idle++;
            if (idle == T - 1) model_abort(2'b11);
        end
    endtask

    task automatic check_model();
        logic exp_busy;
        exp_busy = (frame.size() != 0);
        n_cmp++;
        if (freq0 !== m_f0 || freq1 !== m_f1 || update !== m_upd || upd_ch !== m_ch ||
            err !== m_err || err_code !== m_code || busy !== exp_busy || (update & err)) begin
            n_fail++;
            $display("FAIL model t=%0t: got f0=%h f1=%h upd=%b ch=%b err=%b code=%b busy=%b, want f0=%h f1=%h upd=%b ch=%b err=%b code=%b busy=%b",
                     $time, freq0, freq1, update, upd_ch, err, err_code, busy,
                     m_f0, m_f1, m_upd, m_ch, m_err, m_code, exp_busy);
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    // Called at a negedge; returns at the following negedge.
    task automatic cycle(input logic v, input logic [7:0] d);
        rx_valid = v;
        rx_data  = d;
        model_step(v, d);
        @(posedge clk);
        @(negedge clk);
        rx_valid = 1'b0;
        check_model();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        model_reset();
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check_model();
    endtask

    typedef struct {
        logic [7:0]  b[6];
        int          n;
        logic        upd;
        logic        er;
        logic [1:0]  code;
        logic        ch;
        logic [15:0] f0;
        logic [15:0] f1;
    } vec_t;

    vec_t tbl[5];

    initial begin
        logic [15:0] pf0, pf1;
        logic [7:0]  lo, hi, ad;
        int          got;

`ifdef FREQ_CFG_CHECKSUM_EN
        tbl[0] = '{b:'{8'hA5,8'h00,8'h34,8'h12,8'h26,8'h00}, n:5, upd:1, er:0, code:2'b00, ch:0, f0:16'h1234, f1:F1R};
        tbl[1] = '{b:'{8'hA5,8'h01,8'hCD,8'hAB,8'h67,8'h00}, n:5, upd:1, er:0, code:2'b00, ch:1, f0:16'h1234, f1:16'hABCD};
        tbl[2] = '{b:'{8'hA5,8'h00,8'h34,8'h12,8'h27,8'h00}, n:5, upd:0, er:1, code:2'b10, ch:1, f0:16'h1234, f1:16'hABCD};
        tbl[3] = '{b:'{8'hA5,8'h02,8'h00,8'h00,8'h00,8'h00}, n:2, upd:0, er:1, code:2'b01, ch:1, f0:16'h1234, f1:16'hABCD};
        tbl[4] = '{b:'{8'h55,8'hA5,8'h01,8'hA5,8'hA5,8'h01}, n:6, upd:1, er:0, code:2'b01, ch:1, f0:16'h1234, f1:16'hA5A5};
`else
        tbl[0] = '{b:'{8'hA5,8'h00,8'h34,8'h12,8'h00,8'h00}, n:4, upd:1, er:0, code:2'b00, ch:0, f0:16'h1234, f1:F1R};
        tbl[1] = '{b:'{8'hA5,8'h01,8'hCD,8'hAB,8'h00,8'h00}, n:4, upd:1, er:0, code:2'b00, ch:1, f0:16'h1234, f1:16'hABCD};
        tbl[2] = '{b:'{8'hA5,8'h01,8'h11,8'h22,8'h00,8'h00}, n:4, upd:1, er:0, code:2'b00, ch:1, f0:16'h1234, f1:16'h2211};
        tbl[3] = '{b:'{8'hA5,8'h02,8'h00,8'h00,8'h00,8'h00}, n:2, upd:0, er:1, code:2'b01, ch:1, f0:16'h1234, f1:16'h2211};
        tbl[4] = '{b:'{8'h55,8'hA5,8'h00,8'hA5,8'hA5,8'h00}, n:5, upd:1, er:0, code:2'b01, ch:0, f0:16'hA5A5, f1:16'h2211};
`endif

        rst      = 1'b1;
        rx_valid = 1'b0;
        rx_data  = 8'h00;
        model_reset();
        @(negedge clk);
        chk("rst_freq0", 32'(freq0), 32'(F0R));
        chk("rst_freq1", 32'(freq1), 32'(F1R));
        chk("rst_update", 32'(update), 0);
        chk("rst_upd_ch", 32'(upd_ch), 0);
        chk("rst_err", 32'(err), 0);
        chk("rst_err_code", 32'(err_code), 0);
        chk("rst_busy", 32'(busy), 0);
        do_reset();

        // Table-driven frames
        pf0 = F0R;
        pf1 = F1R;
        for (int i = 0; i < 5; i++) begin
            for (int j = 0; j < tbl[i].n; j++) begin
                cycle(1'b1, tbl[i].b[j]);
                if (j < tbl[i].n - 1) begin
                    chk($sformatf("v%0d_hold_f0", i), 32'(freq0), 32'(pf0));
                    chk($sformatf("v%0d_hold_f1", i), 32'(freq1), 32'(pf1));
                end
            end
            chk($sformatf("v%0d_update", i), 32'(update), 32'(tbl[i].upd));
            chk($sformatf("v%0d_err", i), 32'(err), 32'(tbl[i].er));
            chk($sformatf("v%0d_err_code", i), 32'(err_code), 32'(tbl[i].code));
            chk($sformatf("v%0d_upd_ch", i), 32'(upd_ch), 32'(tbl[i].ch));
            chk($sformatf("v%0d_freq0", i), 32'(freq0), 32'(tbl[i].f0));
            chk($sformatf("v%0d_freq1", i), 32'(freq1), 32'(tbl[i].f1));
            chk($sformatf("v%0d_busy", i), 32'(busy), 0);
            cycle(1'b0, 8'h00);
            chk($sformatf("v%0d_pulse_end", i), 32'({update, err}), 0);
            pf0 = tbl[i].f0;
            pf1 = tbl[i].f1;
        end

        // Timeout latency measured from the address byte
        cycle(1'b1, 8'hA5);
        cycle(1'b1, 8'h00);
        got = -1;
        for (int k = 1; k <= 2 * T; k++) begin
            cycle(1'b0, 8'h00);
            if (err === 1'b1) begin
                got = k;
                break;
            end
        end
        chk("timeout_latency", 32'(got), 32'(T - 1));
        chk("timeout_code", 32'(err_code), 32'(2'b11));
        chk("timeout_busy", 32'(busy), 0);

        // A byte arriving on the expiry cycle wins over the timeout
        cycle(1'b1, 8'hA5);
        cycle(1'b1, 8'h00);
        for (int k = 1; k <= T - 2; k++) cycle(1'b0, 8'h00);
        cycle(1'b1, 8'h34);
        chk("coincide_err", 32'(err), 0);
        chk("coincide_busy", 32'(busy), 1);
        cycle(1'b1, 8'h12);
        if (CSUM_EN) cycle(1'b1, 8'h26);
        chk("coincide_commit_f0", 32'(freq0), 32'h1234);
        chk("coincide_update", 32'(update), 1);

        // Reset in the middle of a frame discards it
        cycle(1'b1, 8'h55);
        cycle(1'b1, 8'hA5);
        cycle(1'b1, 8'h00);
        do_reset();
        chk("midrst_update", 32'(update), 0);
        chk("midrst_err", 32'(err), 0);
        chk("midrst_busy", 32'(busy), 0);
        chk("midrst_f0", 32'(freq0), 32'(F0R));
        cycle(1'b1, 8'hA5);
        cycle(1'b1, 8'h00);
        cycle(1'b1, 8'h78);
        cycle(1'b1, 8'h56);
        if (CSUM_EN) cycle(1'b1, 8'h2E);
        chk("midrst_second_f0", 32'(freq0), 32'h5678);

        // Randomized traffic against the reference model
        for (int it = 0; it < 300; it++) begin
            case ($urandom_range(0, 3))
                0, 1: begin
                    ad = ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 1));
                    lo = 8'($urandom);
                    hi = 8'($urandom);
                    cycle(1'b1, 8'hA5);
                    for (int g = $urandom_range(0, T - 3); g > 0; g--) cycle(1'b0, 8'h00);
                    cycle(1'b1, ad);
                    for (int g = $urandom_range(0, T - 3); g > 0; g--) cycle(1'b0, 8'h00);
                    cycle(1'b1, lo);
                    cycle(1'b1, hi);
                    if (CSUM_EN) begin
                        for (int g = $urandom_range(0, 2); g > 0; g--) cycle(1'b0, 8'h00);
                        cycle(1'b1, ($urandom_range(0, 3) == 0) ? 8'($urandom) : (ad ^ lo ^ hi));
                    end
                end
                2: begin
                    for (int g = 0; g < 6; g++) begin
                        cycle($urandom_range(0, 1) == 1,
                              ($urandom_range(0, 2) == 0) ? 8'hA5 : 8'($urandom_range(0, 3)));
                    end
                end
                default: begin
                    for (int g = $urandom_range(1, T + 4); g > 0; g--) cycle(1'b0, 8'h00);
                end
            endcase
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
